// File: rtl/instruction_fetch_unit.sv
// Program sequencer: holds a small instruction store and issues {opcode, a, b}
// words to the ALU datapath one per valid/ready handshake after start.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [2:0]          opcode_out,
    output logic [7:0]          a_out,
    output logic [7:0]          b_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 valid_q, valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [INSTR_W-1:0]   mem_q [DEPTH];

    // Program store has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == S_IDLE)) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        valid_d = valid_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Lengths beyond the store depth run the whole store once.
                    len_d   = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
                    pc_d    = '0;
                    state_d = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q];
                valid_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    valid_d = 1'b0;
                    if ((LEN_W'(pc_q) + LEN_W'(1)) == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign issue_valid = valid_q;
    assign opcode_out  = instr_q[18:16];
    assign a_out       = instr_q[15:8];
    assign b_out       = instr_q[7:0];
    assign pc_out      = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the stimulus side predicts each
// issued word and its cycle from a plain program model; a monitor checks them.
module tb_instruction_fetch_unit;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 19;
    localparam int unsigned DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [ADDR_W:0]    prog_len;
    logic               start;
    logic               issue_valid;
    logic               issue_ready;
    logic [2:0]         opcode_out;
    logic [7:0]         a_out;
    logic [7:0]         b_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               busy;
    logic               done;

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .opcode_out (opcode_out),
        .a_out      (a_out),
        .b_out      (b_out),
        .pc_out     (pc_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int a;
        int b;
        int pc;
        int cyc;
    } exp_t;

    exp_t               exp_q[$];
    int                 done_q[$];
    logic [INSTR_W-1:0] model_mem [DEPTH];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 ready_mode = 0;
    int                 stall_cnt = 0;
    int                 done_cnt = 0;
    int                 base_done = 0;
    int                 exp_last_pc = 0;
    bit                 seen_first = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ready policy: 0 always, 1 random, 2 stall pc 1 for three cycles, 3 never.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: issue_ready = 1'b1;
            1: issue_ready = 1'($urandom_range(0, 1));
            2: begin
                if (issue_valid && pc_out == 4'd1 && stall_cnt < 3) begin
                    issue_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    issue_ready = 1'b1;
                end
            end
            default: issue_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (rst) begin
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got issue pc=%0d expected none", pc_out);
                end else begin
                    e = exp_q[0];
                    check("opcode", int'(opcode_out), e.op);
                    check("a", int'(a_out), e.a);
                    check("b", int'(b_out), e.b);
                    check("pc", int'(pc_out), e.pc);
                    if (!seen_first && e.cyc >= 0) check("issue_cycle", cyc, e.cyc);
                    seen_first = 1'b1;
                    if (issue_ready) begin
                        void'(exp_q.pop_front());
                        seen_first = 1'b0;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    d = done_q.pop_front();
                    if (d >= 0) check("done_cycle", cyc, d);
                    check("issues_left_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic load_word(input int addr, input logic [INSTR_W-1:0] data);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        model_mem[addr] = data;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic start_run(input int len, input int mode, input bit do_load,
                             input int la, input logic [INSTR_W-1:0] ld);
        int   n, eff, t, hold;
        exp_t e;
        @(posedge clk); #1;
        ready_mode = mode;
        stall_cnt  = 0;
        n = cyc;
        if (do_load) begin
            model_mem[la] = ld;
            load_en   = 1'b1;
            load_addr = ADDR_W'(la);
            load_data = ld;
        end
        eff = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        t = n + 2;
        for (int i = 0; i < eff; i++) begin
            hold  = (mode == 2 && i == 1) ? 4 : 1;
            e.op  = int'(model_mem[i][18:16]);
            e.a   = int'(model_mem[i][15:8]);
            e.b   = int'(model_mem[i][7:0]);
            e.pc  = i;
            e.cyc = (mode == 1) ? -1 : t;
            exp_q.push_back(e);
            t += hold + 1;
        end
        if (mode == 1) done_q.push_back(-1);
        else done_q.push_back((eff == 0) ? n + 1 : t - 1);
        exp_last_pc = (eff == 0) ? 0 : eff - 1;
        base_done   = done_cnt;
        prog_len    = (ADDR_W + 1)'(len);
        start       = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == base_done && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (done_cnt == base_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected a pulse", k);
        end
        check("busy_after_done", int'(busy), 0);
        check("valid_after_done", int'(issue_valid), 0);
        check("final_pc", int'(pc_out), exp_last_pc);
    endtask

    initial begin
        int k;
        rst         = 1'b0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        prog_len    = '0;
        start       = 1'b0;
        issue_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(issue_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pc", int'(pc_out), 0);
        check("rst_instr", int'({opcode_out, a_out, b_out}), 0);
        rst = 1'b1;

        load_word(0, {3'd0, 8'h05, 8'h03});
        load_word(1, {3'd1, 8'h0A, 8'h04});
        load_word(2, {3'd2, 8'hF0, 8'h0F});
        for (int i = 3; i < int'(DEPTH); i++) load_word(i, INSTR_W'($urandom));

        start_run(3, 0, 1'b0, 0, '0);
        wait_done();
        start_run(3, 2, 1'b0, 0, '0);
        wait_done();
        start_run(0, 0, 1'b0, 0, '0);
        wait_done();

        // Writes and a second start while busy must both be ignored.
        start_run(3, 0, 1'b0, 0, '0);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_addr = 4'd1;
        load_data = ~model_mem[1];
        start     = 1'b1;
        prog_len  = 5'd5;
        @(posedge clk); #1;
        load_en = 1'b0;
        start   = 1'b0;
        wait_done();
        start_run(3, 0, 1'b0, 0, '0);
        wait_done();

        // Asynchronous reset while stalled in issue.
        start_run(3, 3, 1'b0, 0, '0);
        k = 0;
        while (!issue_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("stalled_valid_before_rst", int'(issue_valid), 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", int'(issue_valid), 0);
        check("async_rst_pc", int'(pc_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_instr", int'({opcode_out, a_out, b_out}), 0);
        exp_q.delete();
        done_q.delete();
        seen_first = 1'b0;
        ready_mode = 0;
        #1 rst = 1'b1;
        start_run(3, 0, 1'b0, 0, '0);
        wait_done();

        start_run(1, 0, 1'b1, 0, {3'd7, 8'h5A, 8'hA5});
        wait_done();
        start_run(16, 0, 1'b0, 0, '0);
        wait_done();
        start_run(20, 0, 1'b0, 0, '0);
        wait_done();

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) load_word($urandom_range(0, DEPTH - 1), INSTR_W'($urandom));
            start_run($urandom_range(0, 31), 1, 1'b0, 0, '0);
            wait_done();
        end

        repeat (3) @(posedge clk);
        check("leftover_issues", exp_q.size(), 0);
        check("leftover_dones", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
